uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/sync2.sv | 24 ++
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default bit timing
package uart_pkg;

    // Default bit period: 100 MHz system clock at 9600 baud
    localparam int DEFAULT_CLKS_PER_BIT = 10417;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with selectable reset value
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops so the first may resolve metastability before use
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with framing check and packet counting
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PACKET_LEN   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RXD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_error,
    output logic [2:0] byte_count,
    output logic       packet_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // The counter starts at 0 on the first clock after entering START, so the
    // HALF-th clock there sees HALF-1; same reasoning for the full bit period.
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(PACKET_LEN - 1);

    logic             rxs;
    uart_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_idx_d;
    logic [7:0]       shift_reg;
    logic             shift_en;
    logic             stop_good;
    logic             stop_bad;

    sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (RXD),
        .q     (rxs)
    );

    // State, baud counter and bit index registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
        end
    end

    // Next-state logic and per-cycle sample strobes
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_en  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt == HALF_END) begin
                    cnt_d   = '0;
                    // A line that has gone high again by mid-start was noise
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_END) begin
                    cnt_d    = '0;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_END) begin
                    cnt_d = '0;
                    // Leaving at mid-stop lets an immediately following start edge be seen
                    if (rxs) begin
                        stop_good = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // Hold off until a break ends so it is not decoded as frames
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // LSB-first deserializer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {rxs, shift_reg[7:1]};
        end
    end

    // Registered byte, status pulses and packet position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data        <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            byte_count  <= '0;
            packet_done <= 1'b0;
        end else begin
            data_valid  <= stop_good;
            frame_error <= stop_bad;
            packet_done <= stop_good && (byte_count == LAST_BYTE);
            if (stop_good) begin
                data       <= shift_reg;
                byte_count <= (byte_count == LAST_BYTE) ? 3'd0 : byte_count + 3'd1;
            end else if (stop_bad) begin
                byte_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int PLEN = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RXD = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_error;
    logic [2:0] byte_count;
    logic       packet_done;

    uart_receiver #(.CLKS_PER_BIT(CPB), .PACKET_LEN(PLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .RXD         (RXD),
        .data        (data),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .byte_count  (byte_count),
        .packet_done (packet_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [2:0] cnt;
        logic       pd;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [2:0] model_cnt = 3'd0;
    logic [7:0] model_data = 8'h00;
    int         ferr_pending = 0;
    int         prev_valid_cyc = -1;
    int         last_gap = 0;
    int         valid_seen = 0;
    int         ferr_seen = 0;
    int         pd_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every byte, checks every pulse
    always @(negedge clk) begin
        if (reset) begin
            if (data_valid || frame_error)
                check_val("valid_ferr_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
            if (packet_done) pd_seen++;
            if (data_valid) begin
                valid_seen++;
                if (prev_valid_cyc >= 0) last_gap = cyc - prev_valid_cyc;
                prev_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_valid", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("data", {24'd0, data}, {24'd0, e.d});
                    check_val("byte_count", {29'd0, byte_count}, {29'd0, e.cnt});
                    check_val("packet_done", {31'd0, packet_done}, {31'd0, e.pd});
                    model_data = e.d;
                end
            end else if (packet_done) begin
                check_val("packet_done_alone", {31'd0, packet_done}, 32'd0);
            end
            if (frame_error) begin
                ferr_seen++;
                check_val("ferr_expected", {31'd0, ferr_pending > 0}, 32'd1);
                if (ferr_pending > 0) ferr_pending--;
                check_val("ferr_data_kept", {24'd0, data}, {24'd0, model_data});
                check_val("ferr_count_clr", {29'd0, byte_count}, 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_data"}, {24'd0, data}, 32'd0);
        check_val({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
        check_val({tag, "_ferr"}, {31'd0, frame_error}, 32'd0);
        check_val({tag, "_count"}, {29'd0, byte_count}, 32'd0);
        check_val({tag, "_pdone"}, {31'd0, packet_done}, 32'd0);
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives nbits of a frame (start, 8 data LSB first, stop); only full frames are scored
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] f;
        exp_t       x;
        f = {stop_bit, b, 1'b0};
        if (nbits == 10) begin
            if (stop_bit) begin
                x.d   = b;
                x.pd  = (model_cnt == 3'(PLEN - 1));
                x.cnt = x.pd ? 3'd0 : model_cnt + 3'd1;
                model_cnt = x.cnt;
                exp_q.push_back(x);
            end else begin
                ferr_pending++;
                model_cnt = 3'd0;
            end
        end
        for (int i = 0; i < nbits; i++) begin
            RXD = f[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        RXD = 1'b1;
        exp_q.delete();
        model_cnt = 3'd0;
        model_data = 8'h00;
        prev_valid_cyc = -1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(10);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        idle(20);

        // Single byte
        send_frame(8'h41, 1'b1, 10);
        idle(4);
        wait_drain();
        check_val("valid_after_41", valid_seen, 1);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 10);
        send_frame(8'hFF, 1'b1, 10);
        idle(4);
        wait_drain();
        check_val("b2b_gap", last_gap, 10 * CPB);

        // Short low glitch must be rejected
        RXD = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        check_val("glitch_no_valid", valid_seen, 3);
        send_frame(8'h55, 1'b1, 10);
        idle(4);
        wait_drain();

        // Bad stop bit followed by a held-low line
        send_frame(8'hA5, 1'b0, 10);
        RXD = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        check_val("ferr_seen", ferr_seen, 1);
        check_val("ferr_valids", valid_seen, 4);
        check_val("ferr_bc", {29'd0, byte_count}, 32'd0);
        send_frame(8'h3C, 1'b1, 10);
        idle(4);
        wait_drain();

        // Full packet from a clean count
        do_reset();
        pd_seen = 0;
        for (int k = 1; k <= 6; k++) begin
            send_frame(8'(k), 1'b1, 10);
        end
        idle(4);
        wait_drain();
        check_val("pkt_pd_count", pd_seen, 1);
        check_val("pkt_bc_end", {29'd0, byte_count}, 32'd0);

        // Reset during data bit 3
        send_frame(8'h99, 1'b1, 4);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        RXD = 1'b1;
        model_cnt = 3'd0;
        model_data = 8'h00;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(20);
        check_reset_outputs("postrst");
        send_frame(8'h7E, 1'b1, 10);
        idle(4);
        wait_drain();
        check_val("final_bc", {29'd0, byte_count}, 32'd1);
        check_val("final_data", {24'd0, data}, 32'h7E);

        check_val("ferr_pending", ferr_pending, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
